// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_BITS data bits LSB-first, optional parity, STOP_BITS stop bits.
// Define UART_TX_BAUD_SYNC_EN to pass i_baud_clk through a 2-flop synchronizer before edge detection.
module uart_tx_framer #(
    parameter int DATA_BITS   = 8,
    parameter int STOP_BITS   = 1,
    parameter int PARITY_MODE = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_baud_clk,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_tx_stb,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_done_stb,
    output logic                 o_div_start_stb,
    output logic                 o_div_reset_stb,
    output logic [2:0]           o_state
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    state_t               state, state_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [2:0]           bit_cnt, bit_cnt_n;
    logic                 stop_cnt, stop_cnt_n;
    logic                 par, par_n, par_next;
    logic                 tx_n, busy_n, done_n, div_start_n, div_reset_n;
    logic                 baud_cur, baud_q, tick;

`ifdef UART_TX_BAUD_SYNC_EN
    logic baud_s1, baud_s2;
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            baud_s1 <= 1'b1;
            baud_s2 <= 1'b1;
        end else begin
            baud_s1 <= i_baud_clk;
            baud_s2 <= baud_s1;
        end
    end
    assign baud_cur = baud_s2;
`else
    assign baud_cur = i_baud_clk;
`endif

    // One tick per rising edge of the divided clock, i.e. one per bit time.
    assign tick     = !baud_q && baud_cur;
    assign par_next = par ^ shift[0];
    assign o_state  = state;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state           <= IDLE;
            shift           <= '0;
            bit_cnt         <= '0;
            stop_cnt        <= 1'b0;
            par             <= 1'b0;
            baud_q          <= 1'b1;
            o_tx            <= 1'b1;
            o_busy          <= 1'b0;
            o_done_stb      <= 1'b0;
            o_div_start_stb <= 1'b0;
            o_div_reset_stb <= 1'b0;
        end else begin
            state           <= state_n;
            shift           <= shift_n;
            bit_cnt         <= bit_cnt_n;
            stop_cnt        <= stop_cnt_n;
            par             <= par_n;
            baud_q          <= baud_cur;
            o_tx            <= tx_n;
            o_busy          <= busy_n;
            o_done_stb      <= done_n;
            o_div_start_stb <= div_start_n;
            o_div_reset_stb <= div_reset_n;
        end
    end

    always_comb begin
        state_n     = state;
        shift_n     = shift;
        bit_cnt_n   = bit_cnt;
        stop_cnt_n  = stop_cnt;
        par_n       = par;
        tx_n        = o_tx;
        busy_n      = o_busy;
        done_n      = 1'b0;
        div_start_n = 1'b0;
        div_reset_n = 1'b0;
        case (state)
            IDLE: begin
                if (i_tx_stb) begin
                    state_n     = START;
                    shift_n     = i_data;
                    bit_cnt_n   = '0;
                    stop_cnt_n  = 1'b0;
                    par_n       = 1'b0;
                    tx_n        = 1'b0;
                    busy_n      = 1'b1;
                    div_start_n = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_n = DATA;
                    tx_n    = shift[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift_n = shift >> 1;
                    par_n   = par_next;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_n = '0;
                        if (PARITY_MODE != 0) begin
                            state_n = PARITY;
                            tx_n    = (PARITY_MODE == 1) ? ~par_next : par_next;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        tx_n      = shift[1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (stop_cnt == LAST_STOP) begin
                        // Frame ends: divider is stopped so it only runs while a frame is on the wire.
                        state_n     = IDLE;
                        stop_cnt_n  = 1'b0;
                        busy_n      = 1'b0;
                        done_n      = 1'b1;
                        div_reset_n = 1'b1;
                        tx_n        = 1'b1;
                    end else begin
                        stop_cnt_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: four lanes with different frame formats, each driven by a divider model.
// Expected frames are built from the framing rules and checked at every bit boundary by per-lane monitors.
module tb_uart_tx_framer;
    localparam int N   = 4;
    localparam int PER = 20;
`ifdef UART_TX_BAUD_SYNC_EN
    localparam int LAT = PER + 4;
`else
    localparam int LAT = PER + 2;
`endif

    function automatic int cfg_db(input int g);
        return (g == 3) ? 7 : 8;
    endfunction
    function automatic int cfg_sb(input int g);
        return (g == 3) ? 2 : 1;
    endfunction
    function automatic int cfg_pm(input int g);
        return (g == 1) ? 1 : (g == 2) ? 2 : 0;
    endfunction
    function automatic int nbits(input int g);
        return 1 + cfg_db(g) + ((cfg_pm(g) != 0) ? 1 : 0) + cfg_sb(g);
    endfunction
    function automatic logic [7:0] dmask(input int g);
        return (cfg_db(g) == 8) ? 8'hFF : 8'h7F;
    endfunction
    // First cycle (relative to the start strobe) of frame cell i.
    function automatic int cell_start(input int i);
        return (i == 0) ? 0 : LAT + PER * (i - 1);
    endfunction
    function automatic logic cell_bit(input int g, input logic [7:0] d, input int i);
        logic [7:0] md;
        int ones;
        md   = d & dmask(g);
        ones = $countones(md);
        if (i == 0) return 1'b0;
        if (i <= cfg_db(g)) return md[i-1];
        if (cfg_pm(g) != 0 && i == cfg_db(g) + 1)
            return (cfg_pm(g) == 2) ? ones[0] : ~ones[0];
        return 1'b1;
    endfunction

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] baud, tx_stb, tx, busy, done_stb, div_start, div_reset;
    logic [7:0] dat [N];
    logic [2:0] st [N];
    logic [9:0] exp_q[$];
    int         compared = 0;
    int         mismatched = 0;

    initial forever #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : gen_lane
        localparam int DB = cfg_db(g);
        localparam int NB = nbits(g);
        localparam int DONE_T = cell_start(NB);

        logic       run;
        logic [4:0] cnt;
        // Divider model: idles high, first rising edge one full period after start.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                run <= 1'b0;
                cnt <= 5'd0;
            end else if (div_reset[g]) begin
                run <= 1'b0;
                cnt <= 5'd0;
            end else if (div_start[g]) begin
                run <= 1'b1;
                cnt <= 5'd0;
            end else if (run) begin
                cnt <= (cnt == 5'(PER - 1)) ? 5'd0 : cnt + 5'd1;
            end
        end
        assign baud[g] = !run || (cnt < 5'(PER / 2));

        uart_tx_framer #(
            .DATA_BITS(DB), .STOP_BITS(cfg_sb(g)), .PARITY_MODE(cfg_pm(g))
        ) u_dut (
            .i_clk(clk), .i_reset_n(rst_n), .i_baud_clk(baud[g]),
            .i_data(dat[g][DB-1:0]), .i_tx_stb(tx_stb[g]),
            .o_tx(tx[g]), .o_busy(busy[g]), .o_done_stb(done_stb[g]),
            .o_div_start_stb(div_start[g]), .o_div_reset_stb(div_reset[g]),
            .o_state(st[g])
        );

        int         t;
        bit         in_frame;
        logic [9:0] entry;
        logic [7:0] cur;
        initial begin
            t = 0;
            in_frame = 0;
            cur = '0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    in_frame = 0;
                end else begin
                    if (in_frame) t++;
                    if (!in_frame && (done_stb[g] || div_reset[g]))
                        check($sformatf("lane%0d_spurious_end", g), {done_stb[g], div_reset[g]}, 0);
                    if (div_start[g]) begin
                        if (!in_frame && exp_q.size() > 0 && exp_q[0][9:8] == 2'(g)) begin
                            entry = exp_q.pop_front();
                            cur = entry[7:0];
                            in_frame = 1;
                            t = 0;
                        end else begin
                            check($sformatf("lane%0d_unexpected_start", g), div_start[g], 0);
                        end
                    end
                    if (in_frame) begin
                        if (t == DONE_T) begin
                            check($sformatf("lane%0d_done", g), done_stb[g], 1);
                            check($sformatf("lane%0d_div_reset", g), div_reset[g], 1);
                            check($sformatf("lane%0d_busy_end", g), busy[g], 0);
                            check($sformatf("lane%0d_tx_end", g), tx[g], 1);
                            in_frame = 0;
                        end else begin
                            for (int i = 0; i < NB; i++) begin
                                if (t == cell_start(i) || t == cell_start(i + 1) - 1) begin
                                    check($sformatf("lane%0d_bit%0d_t%0d", g, i, t), tx[g], cell_bit(g, cur, i));
                                    check($sformatf("lane%0d_busy_bit%0d", g, i), busy[g], 1);
                                end
                            end
                            if (done_stb[g] || div_reset[g])
                                check($sformatf("lane%0d_early_end", g), {done_stb[g], div_reset[g]}, 0);
                        end
                    end
                end
            end
        end
    end

    task automatic send(input int g, input logic [7:0] d);
        int guard;
        guard = 0;
        while (busy !== 4'b0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) check("send_wait_busy", busy, 0);
        dat[g] = d & dmask(g);
        tx_stb[g] = 1'b1;
        exp_q.push_back({2'(g), d & dmask(g)});
        @(negedge clk);
        tx_stb[g] = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((busy !== 4'b0 || exp_q.size() != 0) && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) check("wait_idle_busy", busy, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [7:0] r;
        tx_stb = '0;
        for (int i = 0; i < N; i++) dat[i] = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {tx, busy, done_stb, div_start, div_reset}, {4'hF, 16'h0});
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_outputs", {tx, busy, done_stb, div_start, div_reset}, {4'hF, 16'h0});
        end

        send(0, 8'hA5);
        wait_idle();
        send(2, 8'h07);
        wait_idle();
        send(1, 8'h07);
        wait_idle();
        send(3, 8'h41);
        send(3, 8'($urandom));
        wait_idle();

        // Requests during a frame and in its completion cycle are dropped.
        r = 8'($urandom);
        send(0, r);
        repeat (LAT + 3 * PER) @(negedge clk);
        dat[0] = ~r;
        tx_stb[0] = 1'b1;
        @(negedge clk);
        tx_stb[0] = 1'b0;
        repeat (cell_start(nbits(0)) - 1 - (LAT + 3 * PER + 1)) @(negedge clk);
        tx_stb[0] = 1'b1;
        @(negedge clk);
        tx_stb[0] = 1'b0;
        repeat (60) @(negedge clk);
        check("ignored_busy_low", busy[0], 0);

        for (int k = 0; k < 12; k++) begin
            send($urandom_range(0, N - 1), 8'($urandom));
            repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        wait_idle();

        // Reset in the middle of data bit 3 (bit forced low so the line visibly returns high).
        r = 8'($urandom) & 8'hF7;
        send(0, r);
        repeat (LAT + 3 * PER + 5) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_tx", tx[0], 1);
        check("async_reset_busy", busy[0], 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_reset_idle", {tx, busy, done_stb, div_start, div_reset}, {4'hF, 16'h0});
        send(0, 8'h3C);
        wait_idle();

        check("leftover_expected", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
- Serial transmitter that consumes the divided baud clock from the team's clock divider and emits one asynchronous frame per request: start bit, DATA_BITS data bits LSB-first, optional parity bit, STOP_BITS stop bits.
- Controls the divider it listens to: it pulses the divider's start strobe when a frame begins and its reset strobe when the frame ends. The divider therefore runs only while a frame is on the wire.
- Sits between the Z80-side I/O register logic and the TX pin.

Parameters:
- DATA_BITS, 8: data bits per frame; legal range 5..8.
- STOP_BITS, 1: stop bits per frame; legal values 1 or 2.
- PARITY_MODE, 0: 0 = no parity, 1 = odd parity, 2 = even parity.

Ports:
- i_clk  input  1  system clock; also the divider's clock.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_baud_clk  input  1  divided clock from the divider; idles high; one full period is one bit time.
- i_data  input  DATA_BITS  byte to send; sampled only on an accepted i_tx_stb.
- i_tx_stb  input  1  one-cycle transmit request.
- o_tx  output  1  serial line; idles high.
- o_busy  output  1  high while a frame is in progress.
- o_done_stb  output  1  one-cycle pulse when a frame completes.
- o_div_start_stb  output  1  one-cycle pulse; connects to the divider's start strobe.
- o_div_reset_stb  output  1  one-cycle pulse; connects to the divider's reset strobe.

Behaviour:
- Reset (async, active-low): o_tx=1, o_busy=0, o_done_stb=0, o_div_start_stb=0, o_div_reset_stb=0, state=IDLE, shift register=0, bit counter=0, baud edge register=1.
  - Reset asserted mid-frame: o_tx returns high immediately, without waiting for a clock edge.
  - No strobe is emitted because of reset.
- Bit boundary:
  - The baud edge register holds the previous i_baud_clk.
  - A tick is one cycle where the previous value is 0 and the current value is 1 (rising edge).
  - After the divider starts, its first rising edge arrives one full period later, so one tick equals one bit time.
- All outputs are registered.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if i_tx_stb=1, then on the next cycle (N+1):
    - o_tx=0, o_busy=1, o_div_start_stb=1 for exactly one cycle;
    - i_data is latched into the shift register;
    - the parity accumulator is cleared;
    - the FSM goes to START.
  - START: on tick, go to DATA and drive o_tx=shift[0].
  - DATA:
    - on each tick, shift right, update parity, increment the bit counter;
    - after DATA_BITS ticks, go to PARITY (PARITY_MODE≠0) or STOP; o_tx=parity bit or 1 respectively.
  - Parity bit value: XOR of the data bits for even parity; its inverse for odd parity.
  - PARITY: on tick, go to STOP with o_tx=1.
  - STOP:
    - counts STOP_BITS ticks;
    - on the last one, in the same cycle: o_div_reset_stb=1, o_done_stb=1, o_busy=0, state=IDLE, o_tx stays 1.
- i_tx_stb handling:
  - Ignored (dropped, no queuing) whenever o_busy=1, including the completion cycle itself.
  - A new request is accepted no earlier than the cycle after o_done_stb.
- A tick while IDLE is ignored.
- Glitch-free line: o_tx changes only on state entry or on a tick.
- Frame length: (1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS) ticks, measured from o_div_start_stb to o_done_stb, plus the divider's start latency.
- Bit counter width: 3 bits plus the stop counter. Bits above DATA_BITS-1 are unused.

Optional Feature:
- Macro: UART_TX_BAUD_SYNC_EN.
- Defined: i_baud_clk passes through a 2-flop synchronizer (both flops reset to 1) before edge detection. Ticks arrive 2 cycles later; everything else is unchanged. Use this when the baud source comes from a different clock domain.
- Undefined: i_baud_clk feeds the edge register directly (same-domain divider).

Test Plan:
- Reset, then idle for 50 cycles -> o_tx=1, o_busy=0, no strobes.
- Bench baud clock of period 20 cycles (high-first after start), i_data=8'hA5, PARITY_MODE=0 -> o_tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 20 cycles wide; o_div_start_stb one cycle after i_tx_stb; o_done_stb and o_div_reset_stb coincide on the 10th tick.
- PARITY_MODE=2 with i_data=8'h07 -> parity bit 1; PARITY_MODE=1 with i_data=8'h07 -> parity bit 0; frame is 11 ticks.
- i_tx_stb pulsed at tick 4 of a frame and again in the o_done_stb cycle -> both ignored; no second frame; o_busy drops.
- i_reset_n pulled low during DATA bit 3 -> o_tx=1 asynchronously, o_busy=0; a fresh i_tx_stb with 8'h3C then transmits correctly.
- STOP_BITS=2, DATA_BITS=7, i_data=7'h41 -> 10-tick frame ending with two high bits; the next frame's start bit begins no earlier than 1 cycle after o_done_stb.
